// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if
//
// Purpose:
//   Groups the bus signals around the instruction-fetch stage. These are the
//   stall vector and branch bus coming in, the IF-to-ID bus going out, and the
//   instruction SRAM request port.
//
// Signals:
//   stall            pipeline stall vector; bit 0 freezes fetch
//   br_bus           {br_e, br_addr[31:0]} redirect request from decode
//   if_to_id_bus     {ce, pc} handed to decode
//   inst_sram_en     fetch enable towards the instruction SRAM
//   inst_sram_wen    byte write enables (fetch never writes)
//   inst_sram_addr   address of the next fetch
//   inst_sram_wdata  write data (fetch never writes)
//   fetch_adel       current pc is a misaligned fetch
//
// Modports:
//   master  the fetch stage itself
//   slave   the surrounding pipeline / memory side
// ---------------------------------------------------------------------------
interface if_stage_if #(
    parameter int STALL_W     = 6,
    parameter int IF_TO_ID_WD = 33,
    parameter int BR_WD       = 33
);
    logic [STALL_W-1:0]     stall;
    logic [BR_WD-1:0]       br_bus;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;
    logic                   fetch_adel;

    modport master (
        input  stall,
        input  br_bus,
        output if_to_id_bus,
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata,
        output fetch_adel
    );

    modport slave (
        output stall,
        output br_bus,
        input  if_to_id_bus,
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        input  fetch_adel
    );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//
// Purpose:
//   Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the PC and
//   presents the next PC to the synchronous instruction SRAM. The instruction
//   word therefore comes back one cycle later, while decode sees the matching
//   PC on if_to_id_bus. Branch/jump redirects from decode are applied at
//   once. If the front end is stalled, the redirect is parked until the next
//   advance.
//
// Ports:
//   clk_i    single clock, all state updates on the rising edge
//   rst_ni   asynchronous active-low reset
//   ifc      if_stage_if.master bundle:
//              stall, br_bus             (in)
//              if_to_id_bus              (out, purely registered {ce, pc})
//              inst_sram_en/wen/addr/wdata (out, SRAM request)
//              fetch_adel                (out, misaligned-fetch flag)
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    if_stage_if.master  ifc
);

    // Decoded inputs
    logic        br_e;
    logic [31:0] br_addr;
    logic        advance;
    logic        unused_stall_bits;

    assign br_e    = ifc.br_bus[32];
    assign br_addr = ifc.br_bus[31:0];
    assign advance = ~ifc.stall[0];

    // Only bit 0 matters to fetch; the other stall bits belong to later stages.
    assign unused_stall_bits = ^ifc.stall[$bits(ifc.stall)-1:1];

    // State registers and their next-state values
    logic [31:0] pc_q,        pc_d;
    logic        ce_q,        ce_d;
    logic        pend_v_q,    pend_v_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic        adel_q,      adel_d;

    logic [31:0] next_pc;
    logic        next_misaligned;

    // A live redirect always wins. Otherwise a redirect parked during a stall
    // is replayed. Otherwise fetch runs sequentially, and the increment wraps
    // at 32 bits.
    always_comb begin
        next_pc = pc_q + 32'd4;
        if (br_e) begin
            next_pc = br_addr;
        end else if (pend_v_q) begin
            next_pc = pend_addr_q;
        end
    end

    assign next_misaligned = (next_pc[1:0] != 2'b00);

    // On an advance, the PC takes next_pc and any parked redirect is used up.
    // While stalled, the PC is frozen. A redirect seen during the stall is
    // parked, and a later one in the same stall replaces it.
    always_comb begin
        pc_d        = pc_q;
        ce_d        = ce_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        adel_d      = adel_q;
        if (advance) begin
            pc_d     = next_pc;
            ce_d     = 1'b1;
            pend_v_d = 1'b0;
            adel_d   = next_misaligned;
        end else if (br_e) begin
            pend_v_d    = 1'b1;
            pend_addr_d = br_addr;
        end
    end

    // State register. Reset drops any parked redirect.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q        <= RESET_PC;
            ce_q        <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= 32'h0;
            adel_q      <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            adel_q      <= adel_d;
        end
    end

    // SRAM request. The fetch enable is gated off while reset is held, so no
    // access leaks out of the reset window. It is also gated off for a
    // misaligned target, so that address never reaches the SRAM.
    assign ifc.inst_sram_addr  = next_pc;
    assign ifc.inst_sram_en    = rst_ni & (advance | ce_q) & ~next_misaligned;
    assign ifc.inst_sram_wen   = 4'b0000;
    assign ifc.inst_sram_wdata = 32'h0;

    // Decode-facing outputs come straight from registers.
    assign ifc.if_to_id_bus = {ce_q, pc_q};
    assign ifc.fetch_adel   = adel_q & ce_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
//
// Purpose:
//   Directed bench for if_stage. Each stimulus step queues the outputs it
//   expects for that cycle. A monitor pops those entries on the falling edge
//   and compares them with what the DUT presents.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        en;
        logic        ce;
        logic [31:0] pc;
        logic        adel;
    } exp_t;

    exp_t expQ[$];

    if_stage_if #(.STALL_W(6), .IF_TO_ID_WD(33), .BR_WD(33)) bus ();

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ifc    (bus.master)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point used by the monitor and by direct checks
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Compares every observable output against one expected record
    task automatic checkAll(input exp_t e);
        checkOutput({e.name, ".addr"}, 64'(bus.inst_sram_addr), 64'(e.addr));
        checkOutput({e.name, ".en"}, 64'(bus.inst_sram_en), 64'(e.en));
        checkOutput({e.name, ".bus"}, 64'(bus.if_to_id_bus), 64'({e.ce, e.pc}));
        checkOutput({e.name, ".adel"}, 64'(bus.fetch_adel), 64'(e.adel));
        checkOutput({e.name, ".wen"}, 64'(bus.inst_sram_wen), 64'(4'b0000));
        checkOutput({e.name, ".wdata"}, 64'(bus.inst_sram_wdata), 64'(32'h0));
    endtask

    // Monitor: pops one expectation per falling edge whenever one is queued
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkAll(e);
        end
    end

    // Drives one cycle of inputs just after the rising edge, then queues
    // the hand-computed outputs expected for that cycle
    task automatic applyStimulus(input logic rstN, input logic stop, input logic brE,
                                 input logic [31:0] brAddr, input string name,
                                 input logic [31:0] expAddr, input logic expEn,
                                 input logic expCe, input logic [31:0] expPc,
                                 input logic expAdel);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n      = rstN;
        bus.stall  = {5'b10101, stop};
        bus.br_bus = {brE, brAddr};
        e.name = name;
        e.addr = expAddr;
        e.en   = expEn;
        e.ce   = expCe;
        e.pc   = expPc;
        e.adel = expAdel;
        expQ.push_back(e);
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.stall  = '0;
        bus.br_bus = '0;

        // Reset, then sequential fetch
        applyStimulus(0, 0, 0, 32'h0, "reset",  32'hBFC0_0000, 0, 0, RESET_PC,      0);
        applyStimulus(1, 0, 0, 32'h0, "seqA",   32'hBFC0_0000, 1, 0, RESET_PC,      0);
        applyStimulus(1, 0, 0, 32'h0, "seqB",   32'hBFC0_0004, 1, 1, 32'hBFC0_0000, 0);
        applyStimulus(1, 0, 0, 32'h0, "seqC",   32'hBFC0_0008, 1, 1, 32'hBFC0_0004, 0);
        applyStimulus(1, 0, 0, 32'h0, "seqD",   32'hBFC0_000C, 1, 1, 32'hBFC0_0008, 0);

        // Unstalled branch
        applyStimulus(1, 0, 1, 32'hBFC0_0100, "brE", 32'hBFC0_0100, 1, 1, 32'hBFC0_000C, 0);
        applyStimulus(1, 0, 0, 32'h0, "brF",    32'hBFC0_0104, 1, 1, 32'hBFC0_0100, 0);

        // Redirect parked during a three-cycle stall
        applyStimulus(1, 1, 1, 32'hBFC0_0200, "stl1", 32'hBFC0_0200, 1, 1, 32'hBFC0_0104, 0);
        applyStimulus(1, 1, 0, 32'h0, "stl2",   32'hBFC0_0200, 1, 1, 32'hBFC0_0104, 0);
        applyStimulus(1, 1, 0, 32'h0, "stl3",   32'hBFC0_0200, 1, 1, 32'hBFC0_0104, 0);
        applyStimulus(1, 0, 0, 32'h0, "rel1",   32'hBFC0_0200, 1, 1, 32'hBFC0_0104, 0);
        applyStimulus(1, 0, 0, 32'h0, "rel2",   32'hBFC0_0204, 1, 1, 32'hBFC0_0200, 0);

        // Two redirects in one stall: the last one wins
        applyStimulus(1, 1, 1, 32'hBFC0_0300, "lw1", 32'hBFC0_0300, 1, 1, 32'hBFC0_0204, 0);
        applyStimulus(1, 1, 1, 32'hBFC0_0400, "lw2", 32'hBFC0_0400, 1, 1, 32'hBFC0_0204, 0);
        applyStimulus(1, 0, 0, 32'h0, "lw3",    32'hBFC0_0400, 1, 1, 32'hBFC0_0204, 0);
        applyStimulus(1, 0, 0, 32'h0, "lw4",    32'hBFC0_0404, 1, 1, 32'hBFC0_0400, 0);

        // Misaligned target: no SRAM access, then flag, then cleared
        applyStimulus(1, 0, 1, 32'hBFC0_0002, "mis1", 32'hBFC0_0002, 0, 1, 32'hBFC0_0404, 0);
        applyStimulus(1, 0, 1, 32'hBFC0_0010, "mis2", 32'hBFC0_0010, 1, 1, 32'hBFC0_0002, 1);
        applyStimulus(1, 0, 0, 32'h0, "mis3",   32'hBFC0_0014, 1, 1, 32'hBFC0_0010, 0);

        // Live redirect beats a parked one and clears it
        applyStimulus(1, 1, 1, 32'hBFC0_0500, "pri1", 32'hBFC0_0500, 1, 1, 32'hBFC0_0014, 0);
        applyStimulus(1, 0, 1, 32'hBFC0_0600, "pri2", 32'hBFC0_0600, 1, 1, 32'hBFC0_0014, 0);
        applyStimulus(1, 0, 0, 32'h0, "pri3",   32'hBFC0_0604, 1, 1, 32'hBFC0_0600, 0);

        // Park a redirect, then reset asynchronously in the middle of the stall
        applyStimulus(1, 1, 1, 32'hBFC0_0700, "ar1", 32'hBFC0_0700, 1, 1, 32'hBFC0_0604, 0);
        @(posedge clk);
        #1;
        bus.br_bus = '0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async.bus",  64'(bus.if_to_id_bus),   64'({1'b0, RESET_PC}));
        checkOutput("async.en",   64'(bus.inst_sram_en),   64'(1'b0));
        checkOutput("async.addr", 64'(bus.inst_sram_addr), 64'(32'hBFC0_0000));
        checkOutput("async.adel", 64'(bus.fetch_adel),     64'(1'b0));

        // Restart after reset: still stalled first, so no fetch yet
        applyStimulus(0, 1, 0, 32'h0, "rs0",    32'hBFC0_0000, 0, 0, RESET_PC,      0);
        applyStimulus(1, 1, 0, 32'h0, "rs1",    32'hBFC0_0000, 0, 0, RESET_PC,      0);
        applyStimulus(1, 0, 0, 32'h0, "rs2",    32'hBFC0_0000, 1, 0, RESET_PC,      0);
        applyStimulus(1, 0, 0, 32'h0, "rs3",    32'hBFC0_0004, 1, 1, 32'hBFC0_0000, 0);

        // Let the monitor drain the queue within a bounded number of cycles
        for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
            @(posedge clk);
        end
        checkOutput("drain", 64'(expQ.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
